operand_skid_buffer: RTL and testbench

OPERAND_SKID_BUFFER -- requirements
Module: operand_skid_buffer

---
 rtl/operand_skid_buffer_pkg.sv | 22 ++
 rtl/operand_skid_buffer_reg_en.sv | 25 ++
 rtl/operand_skid_buffer.sv | 100 ++++++++++
 tb/tb_operand_skid_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_skid_buffer_pkg.sv
// Shared definitions for the operand skid buffer: FSM state type,
// state encodings and small state-decode helpers.
package operand_skid_buffer_pkg;

   typedef logic [1:0] state_t;

   // Number of operand sets held: none, main only, main and skid.
   localparam state_t EMPTY = 2'd0;
   localparam state_t ONE   = 2'd1;
   localparam state_t FULL  = 2'd2;

   // A set is presented downstream whenever main is occupied.
   function automatic logic holds_set(input state_t s);
      return (s == ONE) || (s == FULL);
   endfunction

   // Room for one more set whenever skid is free.
   function automatic logic has_room(input state_t s);
      return (s == EMPTY) || (s == ONE);
   endfunction

endpackage

// File: rtl/operand_skid_buffer_reg_en.sv
// Load-enabled storage register with synchronous active-high clear.
// Ports: clk, reset, en_i (load strobe), d_i (next word), q_o (held word).
module reg_en #(
   parameter int W = 65
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/operand_skid_buffer.sv
// Two-entry skid buffer in front of a 2:1 selector stage.
// Ports: upstream in_valid/in_ready/in_data0/in_data1/in_selec,
// downstream out_valid/out_ready/out_data0/out_data1/out_selec.
module operand_skid_buffer
   import operand_skid_buffer_pkg::*;
#(
   parameter int Nbits = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [Nbits-1:0] in_data0,
   input  logic [Nbits-1:0] in_data1,
   input  logic             in_selec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [Nbits-1:0] out_data0,
   output logic [Nbits-1:0] out_data1,
   output logic             out_selec
);

   localparam int W = 2 * Nbits + 1;

   state_t state_q, state_d;

   logic         main_en, skid_en, main_from_skid;
   logic [W-1:0] in_word, main_d, main_q, skid_q;

   assign in_word = {in_selec, in_data1, in_data0};
   assign main_d  = main_from_skid ? skid_q : in_word;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_valid) begin
               main_en = 1'b1;
               state_d = ONE;
            end
         end
         ONE: begin
            if (in_valid && out_ready) begin
               main_en = 1'b1;
            end else if (in_valid) begin
               // Downstream stalled: park the new set, keep main presented.
               skid_en = 1'b1;
               state_d = FULL;
            end else if (out_ready) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_ready) begin
               main_en        = 1'b1;
               main_from_skid = 1'b1;
               state_d        = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Handshake outputs come from registered state only; reset masks
   // them so nothing transfers on a reset edge.
   assign in_ready  = has_room(state_q) && !reset;
   assign out_valid = holds_set(state_q) && !reset;

   reg_en #(.W(W)) u_main (
      .clk   (clk),
      .reset (reset),
      .en_i  (main_en),
      .d_i   (main_d),
      .q_o   (main_q)
   );

   reg_en #(.W(W)) u_skid (
      .clk   (clk),
      .reset (reset),
      .en_i  (skid_en),
      .d_i   (in_word),
      .q_o   (skid_q)
   );

   assign out_data0 = main_q[Nbits-1:0];
   assign out_data1 = main_q[2*Nbits-1:Nbits];
   assign out_selec = main_q[W-1];

endmodule

// File: tb/tb_operand_skid_buffer.sv
// Self-checking bench for operand_skid_buffer: scoreboard on the
// 32-bit instance plus a directed width check on an 8-bit instance.
module tb_operand_skid_buffer;

   typedef struct {
      logic [64:0] data;
      int          cyc;
   } sb_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_selec;
   logic [31:0] in_data0, in_data1;
   logic        out_valid, out_ready, out_selec;
   logic [31:0] out_data0, out_data1;

   logic       b_in_valid, b_in_ready, b_in_selec;
   logic [7:0] b_in_data0, b_in_data1;
   logic       b_out_valid, b_out_ready, b_out_selec;
   logic [7:0] b_out_data0, b_out_data1;

   sb_t sb[$];
   int  tot = 0, pass = 0;
   int  cyc = 0, acc_cnt = 0, out_cnt = 0;
   bit  lat_chk = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   operand_skid_buffer #(.Nbits(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data0(in_data0), .in_data1(in_data1), .in_selec(in_selec),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data0(out_data0), .out_data1(out_data1), .out_selec(out_selec)
   );

   operand_skid_buffer #(.Nbits(8)) dut8 (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data0(b_in_data0), .in_data1(b_in_data1), .in_selec(b_in_selec),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data0(b_out_data0), .out_data1(b_out_data1), .out_selec(b_out_selec)
   );

   // Scoreboard monitor: handshakes are stable at the falling edge.
   always @(negedge clk) begin
      sb_t e;
      logic [64:0] got;
      if (reset) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            got = {out_selec, out_data1, out_data0};
            out_cnt++;
            tot++;
            if (sb.size() == 0) begin
               $display("FAIL sb_underflow got=%h expected=none", got);
            end else begin
               e = sb.pop_front();
               if (got !== e.data)
                  $display("FAIL sb_data got=%h expected=%h", got, e.data);
               else
                  pass++;
               if (lat_chk) begin
                  tot++;
                  if (cyc !== e.cyc + 1)
                     $display("FAIL latency got=%0d expected=%0d",
                              cyc - e.cyc, 1);
                  else
                     pass++;
               end
            end
         end
         if (in_valid && in_ready) begin
            e.data = {in_selec, in_data1, in_data0};
            e.cyc  = cyc;
            sb.push_back(e);
            acc_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0; in_data0 = '0; in_data1 = '0; in_selec = 1'b0;
      out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data0 = '0; b_in_data1 = '0;
      b_in_selec = 1'b0; b_out_ready = 1'b0;
      tick(); tick();
      @(negedge clk);
      tot++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL rst_hs got=%b%b expected=00", in_ready, out_valid);
      else pass++;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tot++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data0 !== 32'd0)
            $display("FAIL idle got=%b%b %h expected=01 0",
                     out_valid, in_ready, out_data0);
         else pass++;
         tick();
      end
   endtask

   task automatic test_stream();
      int base = out_cnt;
      lat_chk = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data0 = 32'(i + 1);
         in_data1 = 32'(8'hA0 + i);
         in_selec = i[0];
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      lat_chk = 1'b0;
      tot++;
      if (out_cnt - base !== 8)
         $display("FAIL stream_cnt got=%0d expected=8", out_cnt - base);
      else pass++;
   endtask

   task automatic test_skid_fill();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data0 = 32'h11; in_data1 = 32'h0; in_selec = 1'b0;
      tick();
      in_data0 = 32'h22; in_selec = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tot++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data0 !== 32'h11)
            $display("FAIL skid_hold got=%b%b %h expected=01 11",
                     in_ready, out_valid, out_data0);
         else pass++;
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      tot++;
      if (out_valid !== 1'b1 || out_data0 !== 32'h11)
         $display("FAIL skid_first got=%b %h expected=1 11",
                  out_valid, out_data0);
      else pass++;
      tick();
      @(negedge clk);
      tot++;
      if (out_valid !== 1'b1 || out_data0 !== 32'h22)
         $display("FAIL skid_second got=%b %h expected=1 22",
                  out_valid, out_data0);
      else pass++;
      tick();
      @(negedge clk);
      tot++;
      if (out_valid !== 1'b0)
         $display("FAIL skid_empty got=%b expected=0", out_valid);
      else pass++;
      tick();
   endtask

   task automatic test_random();
      int start = acc_cnt;
      int n = 0;
      while (acc_cnt - start < 1000 && n < 20000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data0  = $urandom;
         in_data1  = $urandom;
         in_selec  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      tot++;
      if (acc_cnt - start !== 1000)
         $display("FAIL rand_accept got=%0d expected=1000", acc_cnt - start);
      else pass++;
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 10) begin
         tick();
         n++;
      end
      @(negedge clk);
      tot++;
      if (sb.size() !== 0 || out_valid !== 1'b0)
         $display("FAIL rand_drain got=%0d %b expected=0 0",
                  sb.size(), out_valid);
      else pass++;
      tick();
   endtask

   task automatic test_reset_full();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data0 = 32'hA1; in_data1 = 32'h1; in_selec = 1'b0;
      tick();
      in_data0 = 32'hA2;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      tot++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL full_pre got=%b%b expected=01", in_ready, out_valid);
      else pass++;
      tick();
      reset = 1'b1;
      @(negedge clk);
      tot++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0)
         $display("FAIL full_rst got=%b%b expected=00", out_valid, in_ready);
      else pass++;
      tick();
      reset = 1'b0;
      @(negedge clk);
      tot++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL post_rst got=%b%b expected=01", out_valid, in_ready);
      else pass++;
      tick();
      in_valid = 1'b1; in_data0 = 32'h55; in_data1 = 32'h0;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      tot++;
      if (out_valid !== 1'b1 || out_data0 !== 32'h55)
         $display("FAIL first_after_rst got=%b %h expected=1 55",
                  out_valid, out_data0);
      else pass++;
      tick(); tick();
   endtask

   task automatic test_width8();
      logic [7:0] v0, v1;
      b_out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         v0 = (i == 0) ? 8'hFF : 8'h00;
         v1 = ~v0;
         b_in_valid = 1'b1;
         b_in_data0 = v0;
         b_in_data1 = v1;
         b_in_selec = (i == 0);
         tick();
         b_in_valid = 1'b0;
         @(negedge clk);
         tot++;
         if (b_out_valid !== 1'b1 || b_out_data0 !== v0 ||
             b_out_data1 !== v1 || b_out_selec !== (i == 0))
            $display("FAIL width8 got=%b %h %h %b expected=1 %h %h %b",
                     b_out_valid, b_out_data0, b_out_data1, b_out_selec,
                     v0, v1, (i == 0));
         else pass++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_skid_fill();
      test_random();
      test_reset_full();
      test_width8();
      tick();
      $display("%0d/%0d checks passed", pass, tot);
      $finish;
   end

endmodule
